// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache with one-word frames and a single-word miss fill.
// Optional hit/miss statistics counters are built when ICACHE_STATS_EN is defined.
module icache_direct #(
  parameter int SETS = 16,
  localparam int IDX_W = $clog2(SETS)
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [29:0]      miss_addr_q, miss_addr_d;
  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS];

  logic [IDX_W-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0] req_tag, fill_tag;
  logic             lookup_hit;
  logic             fill_en;
  logic             miss_start;
  logic             unused_offset;

  assign req_idx       = imemaddr[IDX_W+1:2];
  assign req_tag       = imemaddr[31:IDX_W+2];
  assign fill_idx      = miss_addr_q[IDX_W-1:0];
  assign fill_tag      = miss_addr_q[29:IDX_W];
  assign lookup_hit    = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign unused_offset = ^imemaddr[1:0];

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    ihit        = 1'b0;
    imemload    = '0;
    iREN        = 1'b0;
    iaddr       = '0;
    fill_en     = 1'b0;
    miss_start  = 1'b0;
    case (state_q)
      IDLE: begin
        if (imemREN) begin
          if (lookup_hit) begin
            ihit     = 1'b1;
            imemload = data_q[req_idx];
          end else begin
            miss_start  = 1'b1;
            miss_addr_d = imemaddr[31:2];
            state_d     = FETCH;
          end
        end
      end
      FETCH: begin
        // The fill always completes to the latched address, whatever the fetch stage does meanwhile.
        iREN  = 1'b1;
        iaddr = {miss_addr_q, 2'b00};
        if (!iwait) begin
          fill_en = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      if (fill_en) valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; the valid bits guard them.
  always_ff @(posedge CLK) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= iload;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (ihit && (hit_cnt_q != 32'hFFFF_FFFF)) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (miss_start && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the pipeline fetch stage and the memory arbiter.
- Serves imemaddr/imemREN from the datapath and returns ihit/imemload.
- On a miss, issues a single-word read to memory and fills one frame.
- One-word blocks; no write path; no coherence.

Parameters:
- SETS, 16, number of frames; power of two, minimum 2.
- IDX_W, $clog2(SETS), index width; derived, not overridden.

Ports:
- CLK  input  1  clock, rising-edge.
- nRST  input  1  asynchronous active-low reset.
- imemREN  input  1  datapath fetch request.
- imemaddr  input  32  byte address from PC; bits [1:0] ignored.
- ihit  output  1  requested word valid on imemload this cycle.
- imemload  output  32  instruction word.
- iREN  output  1  read request to memory arbiter.
- iaddr  output  32  word-aligned address to memory.
- iwait  input  1  arbiter busy; data valid when iwait=0 while iREN=1.
- iload  input  32  word returned from memory.

Behaviour:
- Address split: offset [1:0]; index [IDX_W+1:2]; tag [31:IDX_W+2].
- Frame contents: valid bit, tag, data.

Reset (nRST low, async):
- All valid bits clear; state IDLE.
- iREN=0, iaddr=0, ihit=0, imemload=0.
- Tag and data arrays need no reset.

FSM states: IDLE, FETCH.

IDLE:
- ihit = imemREN & valid[idx] & (tag[idx]==addr tag), combinational (zero-latency hit).
- imemload = data[idx] on hit, else 0.
- On imemREN & !hit: latch imemaddr into miss_addr; go to FETCH next edge.
- imemREN=0: stay in IDLE, ihit=0.

FETCH:
- iREN=1, iaddr={miss_addr[31:2],2'b00}, ihit=0.
- While iwait=1: hold.
- On edge with iwait=0: write frame at miss_addr index (valid=1, tag, data=iload); return to IDLE.
- The following cycle hits if imemaddr still equals miss_addr.
- Miss latency: 1 cycle to enter FETCH, plus memory wait, plus 1 cycle hit. Minimum 3 cycles from request to ihit.

Boundary conditions:
- imemaddr changes or imemREN drops during FETCH: the fill still completes to miss_addr (arbiter transactions are never aborted). The new address is evaluated in IDLE afterwards.
- Fill to a valid frame: unconditionally overwrites it (conflict eviction, no victim storage).
- Index wrap: addresses 0x00 and SETS*4 map to the same frame and evict each other.
- Async reset mid-FETCH: iREN drops immediately and all frames are invalidated. Partial data is never written.
- iwait=0 in the same edge FETCH is entered: not sampled. iwait is only sampled while in FETCH.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined:
  - Adds outputs hit_count (32) and miss_count (32), both reset to 0.
  - hit_count increments once per cycle with ihit=1.
  - miss_count increments once per IDLE->FETCH transition.
  - Both saturate at 0xFFFFFFFF.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Cold miss:
  - Stimulus: after reset, imemREN=1, imemaddr=0x0000_0040, iwait=1 for 2 cycles then 0, iload=0x2001_0005.
  - Response: iREN=1 with iaddr=0x40 for 3 FETCH cycles, then ihit=1 with imemload=0x2001_0005 in the next IDLE cycle.
- Warm hit:
  - Stimulus: re-request 0x40 after the fill.
  - Response: ihit=1 in the same cycle, iREN stays 0.
- Conflict eviction (SETS=16):
  - Stimulus: fill 0x04 (data 0xAAAA_AAAA), then request 0x44.
  - Response: miss, fill with 0xBBBB_BBBB. A later request to 0x04 misses again.
- Address change mid-fill:
  - Stimulus: miss on 0x08 with iwait=1; switch imemaddr to 0x0C while in FETCH; drop iwait with iload=0x1234_5678.
  - Response: frame 2 holds 0x1234_5678. Next cycle 0x0C misses and a new FETCH starts with iaddr=0x0C.
- Reset mid-FETCH:
  - Stimulus: assert nRST=0 while iREN=1.
  - Response: iREN=0 without waiting for a clock edge. A previously cached 0x40 misses after release.
- Stats (ICACHE_STATS_EN):
  - Stimulus: cold miss on 0x40, then 3 hit cycles.
  - Response: miss_count=1, hit_count=4 (3 hit cycles plus the post-fill hit cycle).
